// File: rtl/fe_inv_seq.sv
// Sequential modular inverse: o_dat = b * a^-1 mod P via binary extended Euclid, one step per clock.
// Latency: 1 cycle accept->o_val for rejected operands, N+1 cycles for N reduction steps.
// Backpressure: single operation in flight; o_rdy only in IDLE, result held while o_val & !i_rdy.
module fe_inv_seq #(
    parameter int                  DAT_BITS = 256,
    parameter logic [DAT_BITS-1:0] P        = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
    parameter int                  CTL_BITS = 8,
    parameter int                  MAX_ITER = 4*DAT_BITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DAT_BITS-1:0] i_a,
    input  logic [DAT_BITS-1:0] i_b,
    input  logic [CTL_BITS-1:0] i_ctl,
    input  logic                i_val,
    output logic                o_rdy,
    output logic [DAT_BITS-1:0] o_dat,
    output logic [CTL_BITS-1:0] o_ctl,
    output logic                o_err,
    output logic                o_val,
    input  logic                i_rdy
);

    localparam int CNT_BITS = $clog2(MAX_ITER + 1);
    localparam logic [DAT_BITS:0] P_EXT = {1'b0, P};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state;
    logic [DAT_BITS-1:0] u, v, x1, x2;
    logic [CNT_BITS-1:0] cnt;

    // x/2 mod P: odd x is made even by adding P first (needs one extra bit).
    function automatic logic [DAT_BITS-1:0] half_mod(input logic [DAT_BITS-1:0] x);
        logic [DAT_BITS:0] s;
        s = x[0] ? ({1'b0, x} + P_EXT) : {1'b0, x};
        return s[DAT_BITS:1];
    endfunction

    function automatic logic [DAT_BITS-1:0] sub_mod(input logic [DAT_BITS-1:0] x,
                                                    input logic [DAT_BITS-1:0] y);
        logic [DAT_BITS:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y)
            d = d + P_EXT;
        return d[DAT_BITS-1:0];
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            o_rdy <= 1'b1;
            o_val <= 1'b0;
            o_err <= 1'b0;
            o_dat <= '0;
            o_ctl <= '0;
            cnt   <= '0;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_val) begin
                        u     <= i_a;
                        v     <= P;
                        x1    <= i_b;
                        x2    <= '0;
                        o_ctl <= i_ctl;
                        cnt   <= '0;
                        o_rdy <= 1'b0;
                        if (i_a == '0 || i_a >= P || i_b >= P) begin
                            o_err <= 1'b1;
                            o_dat <= '0;
                            o_val <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            o_err <= 1'b0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Invariants: x1*a == b*u and x2*a == b*v (mod P).
                    if (u == DAT_BITS'(1)) begin
                        o_dat <= x1;
                        o_val <= 1'b1;
                        state <= S_DONE;
                    end else if (v == DAT_BITS'(1)) begin
                        o_dat <= x2;
                        o_val <= 1'b1;
                        state <= S_DONE;
                    end else if (cnt == CNT_BITS'(MAX_ITER)) begin
                        o_err <= 1'b1;
                        o_dat <= '0;
                        o_val <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_BITS'(1);
                        if (!u[0]) begin
                            u  <= u >> 1;
                            x1 <= half_mod(x1);
                        end else if (!v[0]) begin
                            v  <= v >> 1;
                            x2 <= half_mod(x2);
                        end else if (u >= v) begin
                            u  <= u - v;
                            x1 <= sub_mod(x1, x2);
                        end else begin
                            v  <= v - u;
                            x2 <= sub_mod(x2, x1);
                        end
                    end
                end
                S_DONE: begin
                    if (i_rdy) begin
                        o_val <= 1'b0;
                        o_rdy <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fe_inv_seq.sv
// Bench for fe_inv_seq: default bn128 instance plus an 8-bit P=251 instance, checked against a Fermat-inverse model.
module tb_fe_inv_seq;

    localparam logic [255:0] PBN = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    localparam logic [255:0] INV2 = 256'h183227397098d014dc2822db40c0ac2ecbc0b548b438e5469e10460b6c3e7ea4;
    localparam logic [255:0] P8 = 256'd251;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [255:0] a_l, b_l, dat_l;
    logic [7:0]   c_l, co_l;
    logic         v_l, rdy_l, err_l, ov_l, ir_l;

    logic [7:0]   a_s, b_s, dat_s, c_s, co_s;
    logic         v_s, rdy_s, err_s, ov_s, ir_s;

    fe_inv_seq dut (
        .i_clk(clk), .i_rst(rst), .i_a(a_l), .i_b(b_l), .i_ctl(c_l), .i_val(v_l),
        .o_rdy(rdy_l), .o_dat(dat_l), .o_ctl(co_l), .o_err(err_l), .o_val(ov_l), .i_rdy(ir_l)
    );

    fe_inv_seq #(.DAT_BITS(8), .P(8'd251), .CTL_BITS(8), .MAX_ITER(32)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_a(a_s), .i_b(b_s), .i_ctl(c_s), .i_val(v_s),
        .o_rdy(rdy_s), .o_dat(dat_s), .o_ctl(co_s), .o_err(err_s), .o_val(ov_s), .i_rdy(ir_s)
    );

    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y,
                                            input logic [255:0] p);
        logic [511:0] t;
        t = {256'b0, x} * {256'b0, y};
        t = t % {256'b0, p};
        return t[255:0];
    endfunction

    // Reference: b * a^(p-2) mod p (Fermat), independent of the Euclidean datapath.
    function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] p);
        logic [255:0] e, r, base;
        e = p - 256'd2;
        r = 256'd1;
        base = a;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, base, p);
            base = mulmod(base, base, p);
        end
        return mulmod(r, b, p);
    endfunction

    task automatic op_l(input logic [255:0] a, input logic [255:0] b, input logic [7:0] c,
                        output logic [255:0] d, output logic e, output logic [7:0] co,
                        output int lat, output bit to);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy_l && w < 50) begin @(negedge clk); w++; end
        a_l = a; b_l = b; c_l = c; v_l = 1'b1;
        @(negedge clk);
        v_l = 1'b0;
        lat = 1;
        while (!ov_l && lat < 2000) begin @(negedge clk); lat++; end
        to = !ov_l;
        d = dat_l; e = err_l; co = co_l;
    endtask

    task automatic op_s(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        output logic [7:0] d, output logic e, output logic [7:0] co,
                        output int lat, output bit to);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy_s && w < 50) begin @(negedge clk); w++; end
        a_s = a; b_s = b; c_s = c; v_s = 1'b1;
        @(negedge clk);
        v_s = 1'b0;
        lat = 1;
        while (!ov_s && lat < 100) begin @(negedge clk); lat++; end
        to = !ov_s;
        d = dat_s; e = err_s; co = co_s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_l = '0; b_l = '0; c_l = '0; v_l = 1'b0; ir_l = 1'b1;
        a_s = '0; b_s = '0; c_s = '0; v_s = 1'b0; ir_s = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (rdy_l !== 1'b1) $display("FAIL reset_rdy256 got %b want 1", rdy_l); else n_pass++;
        n_total++; if (ov_l !== 1'b0) $display("FAIL reset_val256 got %b want 0", ov_l); else n_pass++;
        n_total++; if (err_l !== 1'b0) $display("FAIL reset_err256 got %b want 0", err_l); else n_pass++;
        n_total++; if (dat_l !== '0) $display("FAIL reset_dat256 got %h want 0", dat_l); else n_pass++;
        n_total++; if (co_l !== '0) $display("FAIL reset_ctl256 got %h want 0", co_l); else n_pass++;
        n_total++; if (rdy_s !== 1'b1) $display("FAIL reset_rdy8 got %b want 1", rdy_s); else n_pass++;
        n_total++; if (ov_s !== 1'b0) $display("FAIL reset_val8 got %b want 0", ov_s); else n_pass++;
        n_total++; if (dat_s !== '0) $display("FAIL reset_dat8 got %h want 0", dat_s); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_known();
        logic [255:0] d;
        logic [7:0] ds, co;
        logic e;
        int lat;
        bit to;
        op_l(256'd2, 256'd1, 8'h01, d, e, co, lat, to);
        n_total++; if (to || d !== INV2) $display("FAIL inv2_dat got %h want %h", d, INV2); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL inv2_err got %b want 0", e); else n_pass++;
        op_s(8'd3, 8'd1, 8'h02, ds, e, co, lat, to);
        n_total++; if (to || ds !== 8'd84 || e !== 1'b0) $display("FAIL inv3_p251 got %0d err %b want 84 err 0", ds, e); else n_pass++;
        op_s(8'd3, 8'd5, 8'h03, ds, e, co, lat, to);
        n_total++; if (to || ds !== 8'd169 || e !== 1'b0) $display("FAIL scaled_5_3 got %0d err %b want 169 err 0", ds, e); else n_pass++;
        op_s(8'd1, 8'd7, 8'h04, ds, e, co, lat, to);
        n_total++; if (to || ds !== 8'd7) $display("FAIL a1_dat got %0d want 7", ds); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL a1_latency got %0d want 2", lat); else n_pass++;
        n_total++; if (co !== 8'h04) $display("FAIL a1_ctl got %h want 04", co); else n_pass++;
    endtask

    task automatic test_errors();
        logic [255:0] d;
        logic [7:0] ds, co;
        logic e;
        int lat;
        bit to;
        op_s(8'd0, 8'd9, 8'h21, ds, e, co, lat, to);
        n_total++; if (to || e !== 1'b1 || ds !== 8'd0) $display("FAIL a0_err got err %b dat %0d want err 1 dat 0", e, ds); else n_pass++;
        n_total++; if (lat !== 1) $display("FAIL a0_latency got %0d want 1", lat); else n_pass++;
        n_total++; if (co !== 8'h21) $display("FAIL a0_ctl got %h want 21", co); else n_pass++;
        op_s(8'd251, 8'd1, 8'h22, ds, e, co, lat, to);
        n_total++; if (to || e !== 1'b1 || ds !== 8'd0 || lat !== 1) $display("FAIL aP_err got err %b dat %0d lat %0d want 1/0/1", e, ds, lat); else n_pass++;
        op_s(8'd5, 8'd251, 8'h23, ds, e, co, lat, to);
        n_total++; if (to || e !== 1'b1 || ds !== 8'd0) $display("FAIL bP_err got err %b dat %0d want err 1 dat 0", e, ds); else n_pass++;
        op_l(PBN, 256'd1, 8'h24, d, e, co, lat, to);
        n_total++; if (to || e !== 1'b1 || d !== '0 || lat !== 1) $display("FAIL aP256_err got err %b lat %0d want err 1 lat 1", e, lat); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] ds, co;
        logic e;
        int lat;
        bit to;
        ir_s = 1'b0;
        op_s(8'd3, 8'd1, 8'h5A, ds, e, co, lat, to);
        n_total++; if (to || ds !== 8'd84 || co !== 8'h5A) $display("FAIL bp_first got %0d ctl %h want 84 ctl 5a", ds, co); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            a_s = 8'd7; b_s = 8'd2; c_s = 8'h11; v_s = 1'b1;
            @(negedge clk);
            n_total++;
            if (ov_s !== 1'b1 || dat_s !== 8'd84 || co_s !== 8'h5A || rdy_s !== 1'b0)
                $display("FAIL bp_hold cyc %0d got val %b dat %0d ctl %h rdy %b want 1/84/5a/0", i, ov_s, dat_s, co_s, rdy_s);
            else n_pass++;
        end
        v_s = 1'b0;
        ir_s = 1'b1;
        @(negedge clk);
        n_total++; if (ov_s !== 1'b0 || rdy_s !== 1'b1) $display("FAIL bp_release got val %b rdy %b want 0 1", ov_s, rdy_s); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (ov_s !== 1'b0) $display("FAIL bp_ignored got val %b want 0", ov_s); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] ds, co;
        logic e;
        int lat;
        bit to;
        @(negedge clk);
        a_s = 8'd200; b_s = 8'd1; c_s = 8'h33; v_s = 1'b1;
        @(negedge clk);
        v_s = 1'b0;
        @(negedge clk);
        n_total++; if (rdy_s !== 1'b0 || ov_s !== 1'b0) $display("FAIL midrun_busy got rdy %b val %b want 0 0", rdy_s, ov_s); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++; if (ov_s !== 1'b0 || rdy_s !== 1'b1) $display("FAIL midrun_abort got val %b rdy %b want 0 1", ov_s, rdy_s); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (ov_s !== 1'b0) $display("FAIL midrun_no_output got val %b want 0", ov_s); else n_pass++;
        op_s(8'd250, 8'd1, 8'h34, ds, e, co, lat, to);
        n_total++; if (to || ds !== 8'd250 || e !== 1'b0) $display("FAIL post_reset got %0d err %b want 250 err 0", ds, e); else n_pass++;
    endtask

    task automatic test_random_small();
        logic [7:0] a, b, ds, co, ct;
        logic [255:0] exp_v;
        logic e;
        int lat;
        bit to;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(1, 250));
            b = 8'($urandom_range(0, 250));
            ct = 8'($urandom);
            exp_v = model({248'b0, a}, {248'b0, b}, P8);
            op_s(a, b, ct, ds, e, co, lat, to);
            n_total++;
            if (to || e !== 1'b0 || ds !== exp_v[7:0] || co !== ct || lat > 33)
                $display("FAIL rnd8 a=%0d b=%0d got %0d err %b ctl %h lat %0d want %0d ctl %h", a, b, ds, e, co, lat, exp_v[7:0], ct);
            else n_pass++;
        end
    endtask

    task automatic test_random_full();
        logic [255:0] a, b, r, d, exp_v;
        logic [7:0] co;
        logic e;
        int lat;
        bit to;
        for (int i = 0; i < 64; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            a = (r % (PBN - 256'd1)) + 256'd1;
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b = r % PBN;
            exp_v = model(a, b, PBN);
            op_l(a, b, 8'(i), d, e, co, lat, to);
            n_total++;
            if (to || e !== 1'b0 || d !== exp_v || lat - 1 > 1024)
                $display("FAIL rnd256 i=%0d got %h err %b lat %0d want %h", i, d, e, lat, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_errors();
        test_backpressure();
        test_reset_mid_run();
        test_random_small();
        test_random_full();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
